// File: rtl/ihex_pkg.sv
// Shared constants and state encoding for the Intel-HEX streaming loader.
package ihex_pkg;

    localparam logic [7:0] REC_DATA   = 8'h00;
    localparam logic [7:0] REC_EOF    = 8'h01;
    localparam logic [7:0] REC_ESA    = 8'h02;
    localparam logic [7:0] REC_ELA    = 8'h04;
    localparam logic [7:0] CHAR_COLON = 8'h3A;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_H, S_LEN_L,
        S_ADR3, S_ADR2, S_ADR1, S_ADR0,
        S_TYP_H, S_TYP_L,
        S_DAT_H, S_DAT_L,
        S_CS_H, S_CS_L
    } state_t;

endpackage

// File: rtl/ihex_nibble_dec.sv
// Combinational ASCII to hex-nibble decoder; accepts 0-9, A-F and a-f.
module ihex_nibble_dec (
    input  logic [7:0] ch,
    output logic       is_hex,
    output logic [3:0] nibble
);

    // Letters share the low nibble layout: 'A'/'a' = x1 maps to 10.
    always_comb begin
        is_hex = 1'b0;
        nibble = 4'h0;
        if ((ch >= 8'h30) && (ch <= 8'h39)) begin
            is_hex = 1'b1;
            nibble = ch[3:0];
        end else if (((ch >= 8'h41) && (ch <= 8'h46)) || ((ch >= 8'h61) && (ch <= 8'h66))) begin
            is_hex = 1'b1;
            nibble = ch[3:0] + 4'd9;
        end else begin
            is_hex = 1'b0;
            nibble = 4'h0;
        end
    end

endmodule

// File: rtl/ihex_loader.sv
// Streaming Intel-HEX parser emitting ROM byte writes and sticky status flags.
// Define IHEX_EXT_ADDR_EN to honour type 02/04 extended address records.
module ihex_loader #(
    parameter int ADDR_W = 15,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dl_active,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              eof,
    output logic              csum_err,
    output logic              fmt_err,
    output logic              range_err,
    output logic [CNT_W-1:0]  rec_count
);
    import ihex_pkg::*;

    state_t      state_r;
    logic [3:0]  hi_r;
    logic [7:0]  len_r;
    logic [15:0] rec_addr_r;
    logic [7:0]  typ_r;
    logic [7:0]  idx_r;
    logic [7:0]  sum_r;
    logic        dl_prev_r;

    logic        is_hex_s;
    logic [3:0]  nib_s;
    logic [7:0]  byte_s;
    logic [7:0]  sum_next_s;
    logic [19:0] offset_s;
    logic [19:0] wr_addr_s;
    logic        in_range_s;
    logic        dl_rise_s;
    logic        accept_s;

    ihex_nibble_dec u_dec (
        .ch     (in_data),
        .is_hex (is_hex_s),
        .nibble (nib_s)
    );

    assign byte_s     = {hi_r, nib_s};
    assign sum_next_s = sum_r + byte_s;
    assign wr_addr_s  = {4'h0, rec_addr_r + {8'h00, idx_r}} + offset_s;
    assign in_range_s = ((wr_addr_s >> ADDR_W) == 20'h00000);
    assign dl_rise_s  = dl_active & ~dl_prev_r;
    assign accept_s   = dl_active & dl_prev_r & in_valid;

`ifdef IHEX_EXT_ADDR_EN
    logic [15:0] ext_data_r;
    logic [19:0] offset_r;

    // Extended base captured from the payload, committed only on a verified checksum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_data_r <= 16'h0000;
            offset_r   <= 20'h00000;
        end else if (dl_rise_s) begin
            offset_r   <= 20'h00000;
        end else if (accept_s && is_hex_s) begin
            if (state_r == S_DAT_L) begin
                ext_data_r <= {ext_data_r[7:0], byte_s};
            end else if ((state_r == S_CS_L) && (sum_next_s == 8'h00)) begin
                if (typ_r == REC_ESA) begin
                    offset_r <= {ext_data_r, 4'h0};
                end else if (typ_r == REC_ELA) begin
                    offset_r <= {ext_data_r[3:0], 16'h0000};
                end else begin
                    offset_r <= offset_r;
                end
            end else begin
                ext_data_r <= ext_data_r;
            end
        end else begin
            ext_data_r <= ext_data_r;
        end
    end

    assign offset_s = offset_r;
`else
    assign offset_s = 20'h00000;
`endif

    // Record parser FSM with registered write strobe and sticky status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            hi_r       <= 4'h0;
            len_r      <= 8'h00;
            rec_addr_r <= 16'h0000;
            typ_r      <= 8'h00;
            idx_r      <= 8'h00;
            sum_r      <= 8'h00;
            dl_prev_r  <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= {ADDR_W{1'b0}};
            mem_data   <= 8'h00;
            eof        <= 1'b0;
            csum_err   <= 1'b0;
            fmt_err    <= 1'b0;
            range_err  <= 1'b0;
            rec_count  <= {CNT_W{1'b0}};
        end else begin
            dl_prev_r <= dl_active;
            mem_we    <= 1'b0;
            if (!dl_active) begin
                state_r <= S_IDLE;
            end else if (dl_rise_s) begin
                state_r   <= S_IDLE;
                eof       <= 1'b0;
                csum_err  <= 1'b0;
                fmt_err   <= 1'b0;
                range_err <= 1'b0;
                rec_count <= {CNT_W{1'b0}};
            end else if (in_valid) begin
                // Any non-hex character inside a record, ':' included, aborts it
                if ((state_r != S_IDLE) && !is_hex_s) begin
                    fmt_err <= 1'b1;
                    state_r <= S_IDLE;
                end else begin
                    case (state_r)
                        S_IDLE: begin
                            if (in_data == CHAR_COLON) begin
                                sum_r   <= 8'h00;
                                idx_r   <= 8'h00;
                                state_r <= S_LEN_H;
                            end else begin
                                state_r <= S_IDLE;
                            end
                        end
                        S_LEN_H: begin hi_r <= nib_s; state_r <= S_LEN_L; end
                        S_LEN_L: begin len_r <= byte_s; sum_r <= sum_next_s; state_r <= S_ADR3; end
                        S_ADR3:  begin hi_r <= nib_s; state_r <= S_ADR2; end
                        S_ADR2:  begin rec_addr_r[15:8] <= byte_s; sum_r <= sum_next_s; state_r <= S_ADR1; end
                        S_ADR1:  begin hi_r <= nib_s; state_r <= S_ADR0; end
                        S_ADR0:  begin rec_addr_r[7:0] <= byte_s; sum_r <= sum_next_s; state_r <= S_TYP_H; end
                        S_TYP_H: begin hi_r <= nib_s; state_r <= S_TYP_L; end
                        S_TYP_L: begin
                            typ_r   <= byte_s;
                            sum_r   <= sum_next_s;
                            state_r <= (len_r == 8'h00) ? S_CS_H : S_DAT_H;
                        end
                        S_DAT_H: begin hi_r <= nib_s; state_r <= S_DAT_L; end
                        S_DAT_L: begin
                            sum_r <= sum_next_s;
                            idx_r <= idx_r + 8'd1;
                            if (typ_r == REC_DATA) begin
                                if (in_range_s) begin
                                    mem_we   <= 1'b1;
                                    mem_addr <= wr_addr_s[ADDR_W-1:0];
                                    mem_data <= byte_s;
                                end else begin
                                    range_err <= 1'b1;
                                end
                            end else begin
                                mem_we <= 1'b0;
                            end
                            state_r <= ((idx_r + 8'd1) == len_r) ? S_CS_H : S_DAT_H;
                        end
                        S_CS_H:  begin hi_r <= nib_s; state_r <= S_CS_L; end
                        S_CS_L: begin
                            state_r <= S_IDLE;
                            if (sum_next_s == 8'h00) begin
                                if (rec_count != {CNT_W{1'b1}}) begin
                                    rec_count <= rec_count + {{(CNT_W-1){1'b0}}, 1'b1};
                                end else begin
                                    rec_count <= rec_count;
                                end
                                if (typ_r == REC_EOF) begin
                                    eof <= 1'b1;
                                end else begin
                                    eof <= eof;
                                end
                            end else begin
                                csum_err <= 1'b1;
                            end
                        end
                        default: state_r <= S_IDLE;
                    endcase
                end
            end else begin
                state_r <= state_r;
            end
        end
    end

endmodule

// File: tb/tb_ihex_loader.sv
// Directed scoreboard bench for ihex_loader; expected writes are queued at stimulus time.
module tb_ihex_loader;

    localparam int ADDR_W = 15;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              dl_active;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic              eof;
    logic              csum_err;
    logic              fmt_err;
    logic              range_err;
    logic [CNT_W-1:0]  rec_count;

    int compared   = 0;
    int mismatched = 0;
    int exp_addr_q[$];
    int exp_data_q[$];

    ihex_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dl_active (dl_active),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .eof       (eof),
        .csum_err  (csum_err),
        .fmt_err   (fmt_err),
        .range_err (range_err),
        .rec_count (rec_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_char(input logic [7:0] c);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = c;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_char(s[i]);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic expect_wr(input int a, input int d);
        exp_addr_q.push_back(a);
        exp_data_q.push_back(d);
    endtask

    task automatic new_download();
        @(negedge clk);
        dl_active = 1'b0;
        repeat (2) @(negedge clk);
        dl_active = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_flags(input string tag, input logic e_eof, input logic e_cs,
                               input logic e_fmt, input logic e_rng, input int e_cnt);
        check({tag, "_eof"},       32'(eof),       32'(e_eof));
        check({tag, "_csum_err"},  32'(csum_err),  32'(e_cs));
        check({tag, "_fmt_err"},   32'(fmt_err),   32'(e_fmt));
        check({tag, "_range_err"}, 32'(range_err), 32'(e_rng));
        check({tag, "_rec_count"}, 32'(rec_count), 32'(e_cnt));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_we"},   32'(mem_we),   32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_mem_data"}, 32'(mem_data), 32'd0);
        check_flags(tag, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    // Write strobe is one cycle wide, so each write is seen at exactly one falling edge
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            check("wr_expected", 32'(exp_addr_q.size() > 0), 32'd1);
            if (exp_addr_q.size() > 0) begin
                check("wr_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
                check("wr_data", 32'(mem_data), 32'(exp_data_q.pop_front()));
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        dl_active = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n     = 1'b1;
        dl_active = 1'b1;
        repeat (2) @(negedge clk);

        // Basic data record, then a lowercase-hex record
        expect_wr(16'h0000, 8'hAA);
        expect_wr(16'h0001, 8'hBB);
        send_str(":02000000AABB99\r\n");
        check_flags("basic", 1'b0, 1'b0, 1'b0, 1'b0, 1);
        expect_wr(16'h0003, 8'hDD);
        send_str(":01000300dd1F\r\n");
        check_flags("lower", 1'b0, 1'b0, 1'b0, 1'b0, 2);
        check("basic_drained", 32'(exp_addr_q.size()), 32'd0);

        // Bad checksum: writes still land
        new_download();
        check_flags("cleared", 1'b0, 1'b0, 1'b0, 1'b0, 0);
        expect_wr(16'h0000, 8'hAA);
        expect_wr(16'h0001, 8'hBB);
        send_str(":02000000AABB98");
        check_flags("badcs", 1'b0, 1'b1, 1'b0, 1'b0, 0);

        // Non-hex character inside a record, then EOF
        new_download();
        send_str(":0G00");
        check_flags("fmt", 1'b0, 1'b0, 1'b1, 1'b0, 0);
        send_str(":00000001FF");
        check_flags("eof", 1'b1, 1'b0, 1'b1, 1'b0, 1);

        // Out-of-range data byte
        new_download();
        send_str(":01800000552A");
        check_flags("range", 1'b0, 1'b0, 1'b0, 1'b1, 1);

        // Extended segment address followed by data
        new_download();
`ifdef IHEX_EXT_ADDR_EN
        expect_wr(16'h1010, 8'hCC);
`else
        expect_wr(16'h0010, 8'hCC);
`endif
        send_str(":020000020100FB");
        send_str(":01001000CC23");
        check_flags("ext", 1'b0, 1'b0, 1'b0, 1'b0, 2);
        check("ext_drained", 32'(exp_addr_q.size()), 32'd0);

        // ':' mid-record aborts without restarting; the tail is ignored
        new_download();
        send_str(":0100:00000001FF");
        check_flags("midcolon", 1'b0, 1'b0, 1'b1, 1'b0, 0);

        // Drop download mid-record: flags hold while low, clear on the next rise
        send_str(":0200");
        @(negedge clk);
        dl_active = 1'b0;
        repeat (2) @(negedge clk);
        check("dl_low_fmt_hold", 32'(fmt_err), 32'd1);
        dl_active = 1'b1;
        repeat (2) @(negedge clk);
        send_str(":00000001FF");
        check_flags("redl", 1'b1, 1'b0, 1'b0, 1'b0, 1);

        // Asynchronous reset mid-record
        expect_wr(16'h0000, 8'hAA);
        send_str(":02000000AA");
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        send_str(":00000001FF");
        check_flags("post_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1);

        check("final_drained", 32'(exp_addr_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
